// File: rtl/baccarat_pkg.sv
// Shared types and helpers for the baccarat engine.
// Rank constants are also used by the datapath 7-segment decoder.
package baccarat_pkg;

  typedef enum logic [3:0] {
    S_RST,
    S_P1,
    S_D1,
    S_P2,
    S_D2,
    S_CHK,
    S_P3,
    S_BNK,
    S_D3,
    S_DONE
  } bac_state_t;

  localparam logic [3:0] RANK_ACE   = 4'd1;
  localparam logic [3:0] RANK_TWO   = 4'd2;
  localparam logic [3:0] RANK_THREE = 4'd3;
  localparam logic [3:0] RANK_FOUR  = 4'd4;
  localparam logic [3:0] RANK_FIVE  = 4'd5;
  localparam logic [3:0] RANK_SIX   = 4'd6;
  localparam logic [3:0] RANK_SEVEN = 4'd7;
  localparam logic [3:0] RANK_EIGHT = 4'd8;
  localparam logic [3:0] RANK_NINE  = 4'd9;
  localparam logic [3:0] RANK_TEN   = 4'd10;
  localparam logic [3:0] RANK_JACK  = 4'd11;
  localparam logic [3:0] RANK_QUEEN = 4'd12;
  localparam logic [3:0] RANK_KING  = 4'd13;

  // Face cards, tens and illegal codes all count zero.
  function automatic logic [3:0] card_value(
    input logic [3:0] rank
  );
    return (rank <= RANK_NINE) ? rank : 4'd0;
  endfunction

  function automatic logic banker_draws(
    input logic [3:0] dscore,
    input logic [3:0] v
  );
    logic draw;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3: draw = (v != 4'd8);
      4'd4: draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5: draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6: draw = (v >= 4'd6) && (v <= 4'd7);
      default: draw = 1'b0;
    endcase
    return draw;
  endfunction

endpackage

// File: rtl/baccarat_banker_rule.sv
// Combinational banker third-card rule.
// Takes the raw player third-card rank.
module baccarat_banker_rule
  import baccarat_pkg::*;
(
  input  logic [3:0] dscore_i,
  input  logic [3:0] pcard3_i,
  output logic       draw_o
);

  assign draw_o = banker_draws(dscore_i, card_value(pcard3_i));

endmodule

// File: rtl/baccarat_fsm.sv
// Baccarat deal sequencer and third-card rule controller.
// Moore strobes; win lights follow the scores once settled.
module baccarat_fsm
  import baccarat_pkg::*;
(
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       game_done
);

  bac_state_t state_q;
  bac_state_t state_d;
  logic       bank_draw;

  baccarat_banker_rule u_rule (
    .dscore_i (dscore),
    .pcard3_i (pcard3),
    .draw_o   (bank_draw)
  );

  // State register with synchronous active-high reset.
  always_ff @(posedge slow_clock) begin
    if (resetb) state_q <= S_RST;
    else        state_q <= state_d;
  end

  // Next-state selection and state-decoded outputs.
  always_comb begin
    state_d          = state_q;
    load_pcard1      = 1'b0;
    load_pcard2      = 1'b0;
    load_pcard3      = 1'b0;
    load_dcard1      = 1'b0;
    load_dcard2      = 1'b0;
    load_dcard3      = 1'b0;
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;
    game_done        = 1'b0;
    unique case (state_q)
      S_RST: state_d = S_P1;
      S_P1: begin
        load_pcard1 = 1'b1;
        state_d     = S_D1;
      end
      S_D1: begin
        load_dcard1 = 1'b1;
        state_d     = S_P2;
      end
      S_P2: begin
        load_pcard2 = 1'b1;
        state_d     = S_D2;
      end
      S_D2: begin
        load_dcard2 = 1'b1;
        state_d     = S_CHK;
      end
      S_CHK: begin
        if (pscore >= 4'd8 || dscore >= 4'd8)
          state_d = S_DONE;
        else if (pscore <= 4'd5)
          state_d = S_P3;
        else if (dscore <= 4'd5)
          state_d = S_D3;
        else
          state_d = S_DONE;
      end
      S_P3: begin
        load_pcard3 = 1'b1;
        state_d     = S_BNK;
      end
      S_BNK: state_d = bank_draw ? S_D3 : S_DONE;
      S_D3: begin
        load_dcard3 = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        player_win_light = (pscore >= dscore);
        dealer_win_light = (dscore >= pscore);
        game_done        = 1'b1;
      end
      default: state_d = S_RST;
    endcase
  end

endmodule

// File: tb/tb_baccarat_fsm.sv
// Self-checking bench for baccarat_fsm.
// Reference model derives the hand flow from the game rules.
module tb_baccarat_fsm;

  logic       clk;
  logic       resetb;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;
  logic       lp1, lp2, lp3, ld1, ld2, ld3;
  logic       pwin, dwin, done;

  int errors = 0;
  int checks = 0;

  baccarat_fsm dut (
    .slow_clock       (clk),
    .resetb           (resetb),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (lp1),
    .load_pcard2      (lp2),
    .load_pcard3      (lp3),
    .load_dcard1      (ld1),
    .load_dcard2      (ld2),
    .load_dcard3      (ld3),
    .player_win_light (pwin),
    .dealer_win_light (dwin),
    .game_done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle: lp1 ld1 lp2 ld2 lp3 ld3 pwin dwin done
  function automatic logic [8:0] outs();
    return {lp1, ld1, lp2, ld2, lp3, ld3, pwin, dwin, done};
  endfunction

  function automatic bit ref_draw(int d, int v);
    if (d <= 2) return 1'b1;
    if (d == 3) return v != 8;
    if (d >= 7) return 1'b0;
    return (v >= 2 * (d - 3)) && (v <= 7);
  endfunction

  task automatic check(string tag, int step, logic [8:0] exp);
    checks++;
    assert (outs() === exp) else begin
      errors++;
      $error("FAIL %s step %0d: observed %b expected %b",
             tag, step, outs(), exp);
    end
  endtask

  // One hand. Phase 0 drives (p,d), phase 1 (p,bd), phase 2 (fp,fd).
  task automatic hand(string tag, int p, int d, int c3, int bd,
                      int fp, int fd, int hold, int rst_at,
                      bit skip_reset, int exp_done_cycle);
    logic [8:0] eq[$];
    int         ph[$];
    int         v;
    bit         pdraw;
    bit         bdraw;
    eq = {9'b0, 9'b100000000, 9'b010000000,
          9'b001000000, 9'b000100000, 9'b0};
    ph = {0, 0, 0, 0, 0, 0};
    v = (c3 <= 9) ? c3 : 0;
    pdraw = 0;
    bdraw = 0;
    if (!(p >= 8 || d >= 8)) begin
      if (p <= 5) begin
        pdraw = 1;
        bdraw = ref_draw(bd, v);
      end else begin
        bdraw = (d <= 5);
      end
    end
    if (pdraw) begin
      eq.push_back(9'b000010000); ph.push_back(1);
      eq.push_back(9'b0);         ph.push_back(1);
    end
    if (bdraw) begin
      eq.push_back(9'b000001000); ph.push_back(2);
    end
    checks++;
    assert (eq.size() == exp_done_cycle) else begin
      errors++;
      $error("FAIL %s latency: observed %0d expected %0d",
             tag, eq.size(), exp_done_cycle);
    end
    for (int k = 0; k <= hold; k++) begin
      eq.push_back({6'b0, 1'(fp >= fd), 1'(fd >= fp), 1'b1});
      ph.push_back(2);
    end
    pcard3 = 4'(c3);
    if (!skip_reset) begin
      resetb = 1'b1;
      @(posedge clk);
      #1 resetb = 1'b0;
    end
    for (int s = 0; s < eq.size(); s++) begin
      if (s > 0) begin
        @(posedge clk);
        #1;
      end
      pscore = 4'(ph[s] == 2 ? fp : p);
      dscore = 4'(ph[s] == 0 ? d : (ph[s] == 1 ? bd : fd));
      #1 check(tag, s, eq[s]);
      if (s == rst_at) begin
        resetb = 1'b1;
        @(posedge clk);
        #1 resetb = 1'b0;
        #1 check({tag, "_rst"}, s, 9'b0);
        return;
      end
    end
  endtask

  initial begin
    int d3, c, p, dd, lat;
    resetb = 1'b1;
    pscore = 4'd0;
    dscore = 4'd0;
    pcard3 = 4'd0;
    repeat (2) @(posedge clk);
    #1 check("reset", 0, 9'b0);

    hand("natural", 8, 3, 0, 3, 8, 3, 3, -1, 0, 6);
    hand("bank_only", 6, 5, 0, 5, 6, 7, 3, -1, 0, 7);
    hand("queen", 3, 4, 12, 4, 3, 4, 3, -1, 0, 8);
    hand("d3_v8", 2, 3, 8, 3, 2, 3, 3, -1, 0, 8);
    hand("d3_v7", 2, 3, 7, 3, 2, 3, 3, -1, 0, 9);
    hand("tie", 1, 1, 13, 5, 5, 5, 10, -1, 0, 8);
    hand("stand", 7, 6, 0, 6, 7, 6, 3, -1, 0, 6);
    hand("abort_p3", 3, 4, 12, 4, 3, 4, 3, 6, 0, 8);
    hand("restart", 3, 4, 5, 4, 3, 4, 3, -1, 1, 9);
    hand("abort_chk", 9, 9, 0, 9, 9, 9, 3, 5, 0, 6);
    hand("after_chk", 4, 1, 2, 1, 4, 1, 3, -1, 1, 9);
    hand("abort_done", 9, 0, 0, 0, 9, 0, 3, 7, 0, 6);
    hand("after_done", 0, 9, 0, 9, 0, 9, 3, -1, 1, 6);

    for (int d = 0; d < 10; d++) begin
      for (int v = 0; v < 10; v++) begin
        c = v;
        if (v == 0) begin
          c = int'($urandom_range(0, 6));
          if (c > 0) c = c + 9;
        end
        p = int'($urandom_range(0, 5));
        dd = int'($urandom_range(0, 7));
        lat = ref_draw(d, v) ? 9 : 8;
        hand("bank_rule", p, dd, c, d,
             int'($urandom_range(0, 9)),
             int'($urandom_range(0, 9)), 1, -1, 0, lat);
      end
    end

    for (int n = 0; n < 150; n++) begin
      p = int'($urandom_range(0, 9));
      dd = int'($urandom_range(0, 9));
      c = int'($urandom_range(0, 15));
      d3 = int'($urandom_range(0, 9));
      if (p >= 8 || dd >= 8) lat = 6;
      else if (p <= 5) lat = ref_draw(d3, (c <= 9) ? c : 0) ? 9 : 8;
      else lat = (dd <= 5) ? 7 : 6;
      hand("random", p, dd, c, d3,
           int'($urandom_range(0, 9)),
           int'($urandom_range(0, 9)), 2, -1, 0, lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/baccarat_fsm.md
# baccarat_fsm

Control state machine for the baccarat engine. It sequences the datapath's six card-load strobes through the standard deal order and applies the player and banker third-card rules. It reads back the running scores and the player's third card, and drives the win lights once the hand is settled. It sits beside `datapath` in the top level and is clocked by the same `slow_clock`.

## Interface
- No parameters.
- `slow_clock` in 1: the single clock, shared with the datapath registers.
- `resetb` in 1: reset, synchronous and active-high; `resetb`=1 at a `slow_clock` rising edge resets the block.
- `pscore` in 4: player score mod 10 from the datapath, range 0..9.
- `dscore` in 4: dealer score mod 10 from the datapath, range 0..9.
- `pcard3` in 4: raw rank of the player's third card; 1=A, 2..9, 10=10, 11=J, 12=Q, 13=K.
- `load_pcard1`, `load_pcard2`, `load_pcard3` out 1 each: one-cycle load strobes for the player card registers.
- `load_dcard1`, `load_dcard2`, `load_dcard3` out 1 each: one-cycle load strobes for the dealer card registers.
- `player_win_light` out 1: player wins or tie.
- `dealer_win_light` out 1: dealer wins or tie.
- `game_done` out 1: hand settled.

## Operation
- Moore outputs, decoded from the state register only. At most one load strobe is high in any state.
- States and actions:
  - RST: no outputs.
  - P1: `load_pcard1`.
  - D1: `load_dcard1`.
  - P2: `load_pcard2`.
  - D2: `load_dcard2`.
  - CHK: no loads.
  - P3: `load_pcard3`.
  - BNK: no loads.
  - D3: `load_dcard3`.
  - DONE: lights and `game_done`.
- Transitions:
  - RST→P1→D1→P2→D2→CHK, unconditional.
  - CHK, natural: if `pscore`≥8 or `dscore`≥8 → DONE.
  - CHK, player draws: else if `pscore`≤5 → P3.
  - CHK, player stands (`pscore` 6 or 7): if `dscore`≤5 → D3, else → DONE.
  - P3→BNK, unconditional.
  - BNK: if the banker rule holds → D3, else → DONE.
  - D3→DONE, unconditional.
  - DONE is absorbing; the only exit is reset.
- Third-card value: v = `pcard3` if `pcard3`≤9, else 0.
- Banker rule, evaluated in BNK, draws when any of these holds:
  - `dscore`≤2.
  - `dscore`=3 and v≠8.
  - `dscore`=4 and v in 2..7.
  - `dscore`=5 and v in 4..7.
  - `dscore`=6 and v in 6..7.
  - `dscore`≥7 never draws.
- DONE outputs:
  - `player_win_light` = (`pscore` ≥ `dscore`).
  - `dealer_win_light` = (`dscore` ≥ `pscore`).
  - Both lights are high on a tie.
  - `game_done` = 1.
- Comparisons are 4-bit unsigned. Score inputs above 9 are out of contract. Out-of-contract `pcard3` (0, 14, 15) maps to v=0.

## Timing
- Synchronous reset: state goes to RST at the next edge with `resetb`=1; reset mid-hand from any state behaves the same way. All outputs are 0 while in RST.
- The first cycle after reset release is RST. P1 follows on the next edge.
- Each strobe is high for exactly one cycle. The datapath captures the card on the edge that ends that state.
- Scores are sampled only in CHK, BNK and DONE, which are non-loading states entered one cycle after the last load, so the datapath values have settled.
- DONE lights track the score inputs combinationally and stay steady because no further loads occur.
- Latency from the RST state to DONE:
  - Natural or both stand: 6 cycles (RST, P1, D1, P2, D2, CHK).
  - Player stands, banker draws: 7 cycles.
  - Player draws, banker stands: 8 cycles.
  - Both draw: 9 cycles.
- `resetb`=1 in the same cycle as any transition condition: reset wins.

## Structure
- Shared package `baccarat_pkg` holds:
  - the state enum `bac_state_t`;
  - rank constants (`RANK_ACE`…`RANK_KING`);
  - function `card_value(rank)`;
  - function `banker_draws(dscore, v)`.
- The datapath's 7-segment decoder also takes its rank constants from `baccarat_pkg`.
- One optional combinational sub-module, `baccarat_banker_rule`, wraps `banker_draws` so the rule can be unit-tested exhaustively. The FSM itself is one always_ff for the state and one always_comb for next state and outputs.

## Test plan
- Reset, release, `pscore`=8, `dscore`=3 → strobes `load_pcard1`, `load_dcard1`, `load_pcard2`, `load_dcard2` in consecutive cycles, no third-card strobes, DONE at cycle 6, `player_win_light`=1, `dealer_win_light`=0.
- `pscore`=6, `dscore`=5 at CHK → `load_dcard3` only; then `dscore`=7 in DONE → `dealer_win_light`=1, `player_win_light`=0.
- `pscore`=3, `dscore`=4, `pcard3`=12 (v=0) → `load_pcard3` strobes, BNK takes no draw, DONE at cycle 8.
- `pscore`=2, `dscore`=3, `pcard3`=8 → no banker draw; the same case with `pcard3`=7 → `load_dcard3` strobes, DONE at cycle 9.
- Tie: final `pscore`=`dscore`=5 → both lights 1 and `game_done`=1, held steady for 10 further cycles.
- Assert `resetb` while in P3 → RST on the next edge, all outputs 0, then a full deal restarts from P1. Also cover all 10×10 `dscore`×v combinations against `banker_draws`.
